msend_word: RTL and testbench
=============================

MSEND_WORD -- requirements
Module: msend_word

Interface
REQ-001 Parameter DATA_W, default 24, word width in bits (>=2).
REQ-002 Parameter CLK_DIV, default 4, clocks per serial bit (>=1).
REQ-003 Parameter MSB_FIRST, default 1, 1 = MSB shifted first, 0 = LSB first.
REQ-004 Parameter IDLE_LVL, default 0, level driven on sent when not transmitting.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 unit_en  input  1  block enable; low aborts and blocks acceptance.
REQ-008 send_start  input  1  word-valid request.
REQ-009 send_data  input  DATA_W  word to transmit, sampled on acceptance.
REQ-010 send_ready  output  1  block can accept a word this cycle.
REQ-011 sending  output  1  high while a word is being shifted out.
REQ-012 send_done  output  1  one-cycle pulse on final clock of each word.
REQ-013 sent  output  1  serial data out, registered.
REQ-014 bit_stb  output  1  one-cycle pulse on first clock of every bit.

Function
REQ-015 Acceptance SHALL occur on a rising edge where send_start & send_ready; send_data captured then.
REQ-016 send_ready SHALL equal unit_en & ~buf_full (combinational, one-word holding buffer).
REQ-017 FSM states: IDLE, SHIFT; IDLE->SHIFT on acceptance; SHIFT->IDLE at word end with buffer empty and no acceptance that cycle.
REQ-018 Acceptance in IDLE SHALL load the shifter directly (buffer stays empty); sending, sent first bit, bit_stb valid the next cycle.
REQ-019 Each bit SHALL be held on sent for exactly CLK_DIV clocks; a word occupies DATA_W*CLK_DIV clocks.
REQ-020 Bit order per MSB_FIRST: bit DATA_W-1 down to 0, or bit 0 up to DATA_W-1.
REQ-021 Acceptance during SHIFT SHALL load the holding buffer; buf_full set, send_ready low until the buffer drains.
REQ-022 At word end with buffer full, the buffered word SHALL start on the next clock with no gap; sending stays high; buffer clears.
REQ-023 Acceptance on the final clock of a word with buffer empty SHALL bypass into the shifter with no gap.
REQ-024 send_done SHALL pulse on the final clock of every completed word, including back-to-back words.
REQ-025 In IDLE: sending=0, sent=IDLE_LVL, bit_stb=0, send_done=0.
REQ-026 unit_en low in any state SHALL abort within one clock: IDLE, buffer cleared, sent=IDLE_LVL, no send_done for the aborted word.
REQ-027 Divider counter width clog2(CLK_DIV) (min 1), bit counter clog2(DATA_W); both wrap to 0 at word boundaries; CLK_DIV=1 yields bit_stb high every SHIFT clock.
REQ-028 send_start while send_ready low SHALL be ignored; no data corruption.

Reset
REQ-029 rst high SHALL asynchronously force IDLE, clear buffer, counters and shifter; sending=0, send_done=0, bit_stb=0, sent=IDLE_LVL.
REQ-030 rst asserted mid-word SHALL discard current and buffered words; no send_done.
REQ-031 After rst release, send_ready SHALL follow unit_en on the first clock.

Verification (DATA_W=24, CLK_DIV=4, IDLE_LVL=0 unless stated)
REQ-032 MSB_FIRST=1, accept 24'h123456 in IDLE -> sent pattern 0001_0010_0011_0100_0101_0110, each bit 4 clocks; sending high 96 clocks; send_done pulse on clock 96 after acceptance.
REQ-033 MSB_FIRST=0, accept 24'hA5A5A5 -> bits 1,0,1,0,0,1,0,1 repeating from bit 0; bit_stb pulses 24 times, 4 clocks apart.
REQ-034 Accept 24'h000001 then 24'hFFFFFF during SHIFT -> send_ready low after second accept; second word starts with zero gap; two send_done pulses 96 clocks apart; sending never drops.
REQ-035 Drop unit_en at clock 40 of a word with buffer full -> next clock sending=0, sent=0, send_ready=0, no send_done; re-enable and accept 24'h00000F -> clean transmission.
REQ-036 Assert rst at clock 50 of a word -> outputs reset immediately (asynchronously); after release, accept 24'h800000 -> sent high for first 4 clocks only.
REQ-037 CLK_DIV=1, DATA_W=8, accept 8'hC3 -> 8-clock word 1,1,0,0,0,0,1,1; send_done on clock 8.

Source files
------------

// File: rtl/msend_word.sv
// Serializes DATA_W-bit words onto sent, CLK_DIV clocks per bit, through a one-word holding buffer.
// First bit appears one clock after acceptance; send_ready drops while the buffer holds a word.
module msend_word #(
   parameter int DATA_W    = 24,
   parameter int CLK_DIV   = 4,
   parameter int MSB_FIRST = 1,
   parameter int IDLE_LVL  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              unit_en,
   input  logic              send_start,
   input  logic [DATA_W-1:0] send_data,
   output logic              send_ready,
   output logic              sending,
   output logic              send_done,
   output logic              sent,
   output logic              bit_stb
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic             IDLE_BIT = 1'(IDLE_LVL);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state, state_nx;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg, hold_buf, shift_nx, load_src;
   logic              buf_full;
   logic              accept, div_last, word_end, load_direct, load_buf;

   function automatic logic lead_bit(input logic [DATA_W-1:0] v);
      return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
   endfunction

   assign send_ready  = unit_en & ~buf_full;
   assign accept      = send_start & send_ready;
   assign div_last    = (div_cnt == DIV_LAST);
   assign word_end    = (state == SHIFT) & div_last & (bit_cnt == BIT_LAST);
   // buffer can only be full in SHIFT, so acceptance never collides with a buffered reload
   assign load_direct = accept & ((state == IDLE) | (word_end & ~buf_full));
   assign load_buf    = word_end & buf_full;
   assign load_src    = load_buf ? hold_buf : send_data;
   assign shift_nx    = (MSB_FIRST != 0) ? {shreg[DATA_W-2:0], 1'b0}
                                         : {1'b0, shreg[DATA_W-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (!unit_en) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nx = SHIFT;
            SHIFT:   if (word_end && !buf_full && !accept) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      sending   = (state == SHIFT);
      bit_stb   = (state == SHIFT) && (div_cnt == '0);
      send_done = word_end & unit_en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg    <= '0;
         hold_buf <= '0;
         buf_full <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         sent     <= IDLE_BIT;
      end else if (!unit_en) begin
         buf_full <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         sent     <= IDLE_BIT;
      end else begin
         if (load_direct || load_buf) begin
            shreg   <= load_src;
            sent    <= lead_bit(load_src);
            div_cnt <= '0;
            bit_cnt <= '0;
         end else if (state == SHIFT) begin
            if (word_end) begin
               sent    <= IDLE_BIT;
               div_cnt <= '0;
               bit_cnt <= '0;
            end else if (div_last) begin
               shreg   <= shift_nx;
               sent    <= lead_bit(shift_nx);
               div_cnt <= '0;
               bit_cnt <= bit_cnt + BIT_W'(1);
            end else begin
               div_cnt <= div_cnt + DIV_W'(1);
            end
         end
         if (load_buf) begin
            buf_full <= 1'b0;
         end else if (accept && state == SHIFT && !word_end) begin
            hold_buf <= send_data;
            buf_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_msend_word.sv
// Directed bench: dut0 default, dut1 LSB-first, dut2 8-bit with CLK_DIV=1; all share stimulus.
module tb_msend_word;

   logic        clk, rst, unit_en, send_start;
   logic [23:0] send_data;
   logic [2:0]  rdy_o, sending_o, done_o, sent_o, stb_o;
   int          total = 0;
   int          bad   = 0;

   msend_word dut0 (
      .clk(clk), .rst(rst), .unit_en(unit_en), .send_start(send_start), .send_data(send_data),
      .send_ready(rdy_o[0]), .sending(sending_o[0]), .send_done(done_o[0]), .sent(sent_o[0]),
      .bit_stb(stb_o[0]));

   msend_word #(.MSB_FIRST(0)) dut1 (
      .clk(clk), .rst(rst), .unit_en(unit_en), .send_start(send_start), .send_data(send_data),
      .send_ready(rdy_o[1]), .sending(sending_o[1]), .send_done(done_o[1]), .sent(sent_o[1]),
      .bit_stb(stb_o[1]));

   msend_word #(.DATA_W(8), .CLK_DIV(1)) dut2 (
      .clk(clk), .rst(rst), .unit_en(unit_en), .send_start(send_start), .send_data(send_data[7:0]),
      .send_ready(rdy_o[2]), .sending(sending_o[2]), .send_done(done_o[2]), .sent(sent_o[2]),
      .bit_stb(stb_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          w;
      logic [23:0] d;
      logic [23:0] seq;   // seq[n-1] is the first bit expected on the line
      int          n;
      int          div;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (sending_o != 3'b000 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("idle reached", 32'(sending_o), 32'h0);
   endtask

   task automatic check_word(input int w, input logic [23:0] d, input logic [23:0] seq,
                             input int n, input int div, input string nm);
      int stbs = 0;
      wait_idle();
      send_data  = d;
      send_start = 1'b1;
      for (int c = 1; c <= n * div; c++) begin
         @(negedge clk);
         if (c == 1) send_start = 1'b0;
         chk({nm, " sending"}, 32'(sending_o[w]), 32'h1);
         chk({nm, " sent"}, 32'(sent_o[w]), 32'(seq[n - 1 - (c - 1) / div]));
         chk({nm, " bit_stb"}, 32'(stb_o[w]), 32'(((c - 1) % div) == 0));
         chk({nm, " send_done"}, 32'(done_o[w]), 32'(c == n * div));
         if (stb_o[w]) stbs++;
      end
      @(negedge clk);
      chk({nm, " stb count"}, 32'(stbs), 32'(n));
      chk({nm, " end sending"}, 32'(sending_o[w]), 32'h0);
      chk({nm, " end sent"}, 32'(sent_o[w]), 32'h0);
      chk({nm, " end done"}, 32'(done_o[w]), 32'h0);
   endtask

   initial begin
      logic [23:0] wd;
      int          k;

      tbl[0] = '{0, 24'h123456, 24'b0001_0010_0011_0100_0101_0110, 24, 4};
      tbl[1] = '{0, 24'h800000, 24'b1000_0000_0000_0000_0000_0000, 24, 4};
      tbl[2] = '{1, 24'hA5A5A5, 24'b10100101_10100101_10100101, 24, 4};
      tbl[3] = '{1, 24'h000001, 24'b1000_0000_0000_0000_0000_0000, 24, 4};
      tbl[4] = '{2, 24'h0000C3, 24'b0000_0000_0000_0000_1100_0011, 8, 1};
      tbl[5] = '{2, 24'h000001, 24'b0000_0000_0000_0000_0000_0001, 8, 1};

      rst = 1'b1; unit_en = 1'b0; send_start = 1'b0; send_data = '0;
      @(negedge clk);
      @(negedge clk);
      chk("reset sending", 32'(sending_o), 32'h0);
      chk("reset sent", 32'(sent_o), 32'h0);
      chk("reset bit_stb", 32'(stb_o), 32'h0);
      chk("reset done", 32'(done_o), 32'h0);
      chk("reset ready", 32'(rdy_o), 32'h0);
      rst = 1'b0; unit_en = 1'b1;
      @(negedge clk);
      chk("ready after reset", 32'(rdy_o), 32'h7);

      for (int i = 0; i < 6; i++)
         check_word(tbl[i].w, tbl[i].d, tbl[i].seq, tbl[i].n, tbl[i].div, $sformatf("vec%0d", i));

      // back-to-back through the holding buffer, with an ignored request while full
      wait_idle();
      send_data = 24'h000001; send_start = 1'b1;
      for (int c = 1; c <= 196; c++) begin
         @(negedge clk);
         if (c == 1) send_start = 1'b0;
         wd = (c <= 96) ? 24'h000001 : 24'hFFFFFF;
         k  = (c - 1) % 96;
         chk("b2b sending", 32'(sending_o[0]), 32'(c <= 192));
         chk("b2b sent", 32'(sent_o[0]), (c <= 192) ? 32'(wd[23 - k / 4]) : 32'h0);
         chk("b2b bit_stb", 32'(stb_o[0]), 32'((c <= 192) && (k % 4 == 0)));
         chk("b2b done", 32'(done_o[0]), 32'(c == 96 || c == 192));
         chk("b2b ready", 32'(rdy_o[0]), 32'(c <= 10 || c >= 97));
         if (c == 10) begin send_data = 24'hFFFFFF; send_start = 1'b1; end
         if (c == 11) send_start = 1'b0;
         if (c == 50) begin send_data = 24'h0F0F0F; send_start = 1'b1; end
         if (c == 51) send_start = 1'b0;
      end

      // abort with the buffer full
      wait_idle();
      send_data = 24'hFFFFFF; send_start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 1) send_start = 1'b0;
         chk("abort sending", 32'(sending_o[0]), 32'(c <= 40));
         chk("abort sent", 32'(sent_o[0]), 32'(c <= 40));
         chk("abort done", 32'(done_o[0]), 32'h0);
         chk("abort ready", 32'(rdy_o[0]), 32'(c <= 5 || c >= 46));
         if (c == 5) begin send_data = 24'h0000AA; send_start = 1'b1; end
         if (c == 6) send_start = 1'b0;
         if (c == 40) unit_en = 1'b0;
         if (c == 45) unit_en = 1'b1;
      end
      check_word(0, 24'h00000F, 24'h00000F, 24, 4, "after abort");

      // asynchronous reset mid-word
      wait_idle();
      send_data = 24'hFFFFFF; send_start = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         if (c == 1) send_start = 1'b0;
         chk("pre-rst sending", 32'(sending_o[0]), 32'h1);
         chk("pre-rst sent", 32'(sent_o[0]), 32'h1);
      end
      #1 rst = 1'b1;
      #1;
      chk("async rst sending", 32'(sending_o[0]), 32'h0);
      chk("async rst sent", 32'(sent_o[0]), 32'h0);
      chk("async rst stb", 32'(stb_o[0]), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         chk("post-rst sending", 32'(sending_o[0]), 32'h0);
         chk("post-rst done", 32'(done_o[0]), 32'h0);
         chk("post-rst ready", 32'(rdy_o[0]), 32'h1);
      end
      check_word(0, 24'h800000, 24'h800000, 24, 4, "after rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
